hazard_stall_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage core. Drives PC hold, the IF/ID

---
 rtl/hazard_stall_ctrl_if.sv | 58 +++++
 rtl/hazard_stall_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of hazard/sequencing signals between the pipeline datapath and the
// stall/flush controller. The datapath side is the master and drives the
// hazard sources; the controller is the slave and drives the pipeline
// control lines and performance counters.
interface hazard_stall_ctrl_if #(
    parameter int FC_W = 16
);
    // Hazard sources sampled from the pipeline
    logic [4:0]      ID_rs1_i;
    logic [4:0]      ID_rs2_i;
    logic [4:0]      EX_rd_i;
    logic            EX_memread_i;
    logic            MEM_req_i;
    logic            branch_taken_i;

    // Pipeline control returned by the controller
    logic            pc_hold_o;
    logic            ifid_stall_o;
    logic            ifid_flush_o;
    logic            idex_bubble_o;
    logic            freeze_o;

    // Performance counters
    logic [31:0]     stall_cycles_o;
    logic [FC_W-1:0] flush_count_o;

    modport master (
        output ID_rs1_i,
        output ID_rs2_i,
        output EX_rd_i,
        output EX_memread_i,
        output MEM_req_i,
        output branch_taken_i,
        input  pc_hold_o,
        input  ifid_stall_o,
        input  ifid_flush_o,
        input  idex_bubble_o,
        input  freeze_o,
        input  stall_cycles_o,
        input  flush_count_o
    );

    modport slave (
        input  ID_rs1_i,
        input  ID_rs2_i,
        input  EX_rd_i,
        input  EX_memread_i,
        input  MEM_req_i,
        input  branch_taken_i,
        output pc_hold_o,
        output ifid_stall_o,
        output ifid_flush_o,
        output idex_bubble_o,
        output freeze_o,
        output stall_cycles_o,
        output flush_count_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Produces PC hold, IF/ID stall and flush, and ID/EX bubble insertion for
// load-use hazards, multi-cycle data-memory freezes and taken branches.
// A branch that resolves while the pipe is frozen is remembered in
// flush_pend and its flush is issued on the first unfrozen cycle.
// Also keeps a saturating stall-cycle counter and a wrapping flush counter.
module hazard_stall_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int FC_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_stall_ctrl_if.slave   bus
);

    // Counter wide enough to hold MEM_LAT-2 for any legal latency
    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    // A latency of 1 completes in a single MEM cycle and never freezes
    localparam bit MULTI = (MEM_LAT > 1);

    // Remaining frozen cycles after the entry cycle; unused when MEM_LAT==1
    localparam int CNT_LOAD_INT = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_LOAD_INT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t          st;
    state_t          st_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic            flush_pend;
    logic            flush_pend_nxt;
    logic [31:0]     stall_cnt;
    logic [FC_W-1:0] flush_cnt;

    logic            frz;
    logic            lu;
    logic            hold;
    logic            flush;
    logic            rs_match;

    // Hazard detection: freeze has priority, load-use next, then branch flush
    always_comb begin
        frz      = 1'b0;
        lu       = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
        rs_match = 1'b0;

        if (st == MEM_WAIT) begin
            frz = (cnt != '0);
        end else begin
            frz = bus.MEM_req_i && MULTI;
        end

        rs_match = (bus.EX_rd_i == bus.ID_rs1_i) || (bus.EX_rd_i == bus.ID_rs2_i);
        lu       = !frz && bus.EX_memread_i && (bus.EX_rd_i != 5'd0) && rs_match;
        hold     = frz || lu;
        flush    = !frz && !lu && (bus.branch_taken_i || flush_pend);
    end

    // Drive the pipeline controls, forcing everything quiet while in reset
    always_comb begin
        bus.freeze_o      = 1'b0;
        bus.pc_hold_o     = 1'b0;
        bus.ifid_stall_o  = 1'b0;
        bus.idex_bubble_o = 1'b0;
        bus.ifid_flush_o  = 1'b0;
        if (!rst_i) begin
            bus.freeze_o      = frz;
            bus.pc_hold_o     = hold;
            bus.ifid_stall_o  = hold;
            bus.idex_bubble_o = lu;
            bus.ifid_flush_o  = flush;
        end
    end

    assign bus.stall_cycles_o = stall_cnt;
    assign bus.flush_count_o  = flush_cnt;

    // Memory-freeze sequencing and deferred-flush bookkeeping
    always_comb begin
        st_nxt         = st;
        cnt_nxt        = cnt;
        flush_pend_nxt = flush_pend;

        unique case (st)
            RUN: begin
                if (bus.MEM_req_i && MULTI) begin
                    st_nxt  = MEM_WAIT;
                    cnt_nxt = CNT_LOAD;
                end
            end
            MEM_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    st_nxt = RUN;
                end
            end
            default: begin
                st_nxt  = RUN;
                cnt_nxt = '0;
            end
        endcase

        if (flush) begin
            flush_pend_nxt = 1'b0;
        end else if (frz && bus.branch_taken_i) begin
            flush_pend_nxt = 1'b1;
        end
    end

    // State register with synchronous reset; reset mid-freeze abandons it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st         <= RUN;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            st         <= st_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // Performance counters: stalls saturate, flushes wrap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hold && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush) begin
                flush_cnt <= flush_cnt + FC_W'(1);
            end
        end
    end

endmodule
